barrel_shift_pipe: RTL

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/barrel_shift_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, LSB first.
// A single advance enable stalls every stage together under output backpressure.
module barrel_shift_pipe #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   shamt,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             out_zero
);

   localparam logic [2:0] ModeSll = 3'd0;
   localparam logic [2:0] ModeSrl = 3'd1;
   localparam logic [2:0] ModeSra = 3'd2;
   localparam logic [2:0] ModeRol = 3'd3;
   localparam logic [2:0] ModeRor = 3'd4;

   logic [WIDTH-1:0] data_q [SHW];
   logic [WIDTH-1:0] data_d [SHW];
   logic [2:0]       mode_q [SHW];
   logic [2:0]       mode_d [SHW];
   logic             sign_q [SHW];
   logic             sign_d [SHW];
   logic [SHW-1:0]   rem_q  [SHW];
   logic [SHW-1:0]   rem_d  [SHW];
   logic [SHW-1:0]   valid_q, valid_d;
   logic             out_zero_q, out_zero_d;
   logic             adv;

   // Inputs seen by each stage: stage 0 from the ports, stage k from stage k-1.
   logic [WIDTH-1:0] st_data  [SHW];
   logic [2:0]       st_mode  [SHW];
   logic             st_sign  [SHW];
   logic [SHW-1:0]   st_rem   [SHW];
   logic [SHW-1:0]   st_valid;

   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       m,
                                                   input logic             sgn,
                                                   input int unsigned      amt);
      logic [WIDTH-1:0] r;
      case (m)
         ModeSll: r = d << amt;
         ModeSrl: r = d >> amt;
         ModeSra: r = (d >> amt) | (sgn ? ~({WIDTH{1'b1}} >> amt) : '0);
         ModeRol: r = (d << amt) | (d >> (WIDTH - amt));
         ModeRor: r = (d >> amt) | (d << (WIDTH - amt));
         default: r = d;
      endcase
      return r;
   endfunction

   always_comb begin
      adv = !valid_q[SHW-1] || out_ready;

      st_data[0]  = din;
      st_mode[0]  = mode;
      st_sign[0]  = din[WIDTH-1];
      st_rem[0]   = shamt;
      st_valid[0] = in_valid;
      for (int k = 1; k < SHW; k++) begin
         st_data[k]  = data_q[k-1];
         st_mode[k]  = mode_q[k-1];
         st_sign[k]  = sign_q[k-1];
         st_rem[k]   = rem_q[k-1];
         st_valid[k] = valid_q[k-1];
      end

      // Bit 0 of the remaining shift amount always belongs to the current stage.
      for (int k = 0; k < SHW; k++) begin
         valid_d[k] = st_valid[k];
         data_d[k]  = st_rem[k][0] ?
                      shift_step(st_data[k], st_mode[k], st_sign[k], 32'd1 << k) :
                      st_data[k];
         mode_d[k]  = st_mode[k];
         sign_d[k]  = st_sign[k];
         rem_d[k]   = st_rem[k] >> 1;
      end

      out_zero_d = valid_d[SHW-1] && (data_d[SHW-1] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         out_zero_q <= 1'b0;
         for (int k = 0; k < SHW; k++) begin
            data_q[k] <= '0;
            mode_q[k] <= '0;
            sign_q[k] <= 1'b0;
            rem_q[k]  <= '0;
         end
      end else if (adv) begin
         valid_q    <= valid_d;
         out_zero_q <= out_zero_d;
         for (int k = 0; k < SHW; k++) begin
            data_q[k] <= data_d[k];
            mode_q[k] <= mode_d[k];
            sign_q[k] <= sign_d[k];
            rem_q[k]  <= rem_d[k];
         end
      end
   end

   assign in_ready  = !rst && adv;
   assign out_valid = valid_q[SHW-1];
   assign dout      = data_q[SHW-1];
   assign out_zero  = out_zero_q;

endmodule
